pic_prio_core: RTL and testbench
================================

Name: pic_prio_core

Overview:
- Clocked, parametrised interrupt priority core for the 8259A-compatible controller.
- Holds the in-service register (ISR) and a rotating lowest-priority pointer.
- Resolves masked requests in fully-nested or special-mask mode and drives INTR.
- Runs a two-pulse INTA handshake that freezes the winner and then delivers its vector.
- Handles non-specific, specific and automatic EOI, each with optional rotation; sits between the IRR/IMR register file and the bus/cascade interface.

Parameters:
- NCH, 8, number of interrupt channels (2..32).
- IDW, $clog2(NCH), width of the channel index.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- irr  in  NCH  latched request register; level, bit i = channel i.
- imr  in  NCH  mask register; 1 = masked.
- smm  in  1  special mask mode enable.
- aeoi  in  1  automatic EOI mode.
- inta  in  1  one-cycle pulse per INTA bus cycle.
- eoi_ns  in  1  non-specific EOI command pulse.
- eoi_sp  in  1  specific EOI command pulse.
- eoi_lvl  in  IDW  target channel for eoi_sp.
- eoi_rot  in  1  rotate on the accompanying EOI (or on AEOI).
- set_lp  in  1  pulse: load lowest-priority pointer.
- lp_lvl  in  IDW  value for set_lp.
- intr  out  1  interrupt request to the CPU (registered).
- vec_valid  out  1  one-cycle pulse; vec_id is valid.
- vec_id  out  IDW  delivered channel.
- spurious  out  1  qualifies vec_valid; no real winner.
- isr  out  NCH  in-service register.
- lp  out  IDW  current lowest-priority channel.

Behaviour:
- Reset (sync): intr=0, vec_valid=0, vec_id=0, spurious=0, isr=0, lp=NCH-1 (channel 0 highest), FSM=IDLE. Reset overrides every other input, including mid-handshake.
- Priority order: lp+1, lp+2, ..., lp, modulo NCH. All index arithmetic wraps modulo NCH; for non-power-of-two NCH, wrap explicitly rather than relying on bit truncation.
- Candidate set: nmr = irr & ~imr; when smm=1, nmr additionally &= ~isr.
- Pending rules:
  - smm=1: pending = (nmr != 0).
  - smm=0: pending = (nmr != 0) AND (isr == 0, or the highest nmr channel has strictly higher rotated priority than the highest isr channel). An equal channel does not preempt.
- intr <= pending && state==IDLE. One-cycle latency from irr/imr/isr/lp changes.
- FSM states: IDLE, FROZEN.
  - IDLE + inta: capture win_id = highest nmr channel and win_ok = pending; go to FROZEN; intr <= 0.
  - FROZEN: intr held 0; irr/imr changes ignored; the captured win_id is kept.
  - FROZEN + inta: vec_valid <= 1 next cycle; go to IDLE.
    - win_ok=1: vec_id <= win_id, spurious <= 0. If aeoi=0, set isr[win_id]. If aeoi=1, do not set isr; if eoi_rot=1, lp <= win_id.
    - win_ok=0 (request withdrawn before the first INTA): vec_id <= NCH-1, spurious <= 1, isr unchanged.
  - FROZEN has no timeout; only inta or rst leaves it.
- Non-specific EOI (eoi_ns): clear the highest-priority set isr bit under the current lp. If eoi_rot=1, lp <= that id. No-op if isr==0.
- Specific EOI (eoi_sp): clear isr[eoi_lvl]. If eoi_rot=1, lp <= eoi_lvl. If eoi_lvl >= NCH, the command is ignored.
- eoi_ns and eoi_sp in the same cycle: eoi_sp wins; eoi_ns is dropped.
- EOI on the same cycle as the second inta:
  - Both apply.
  - If both target the same bit, the set wins.
  - The EOI search uses the pre-set isr.
- lp updates: set_lp has priority over any EOI/AEOI rotation in the same cycle. lp_lvl >= NCH is ignored.
- isr and lp are registered; their effect on intr appears one cycle after they update.
- vec_valid is a single-cycle pulse; vec_id/spurious hold their values until the next delivery.

Decomposition:
- Shared package pic_pkg: state enum {IDLE, FROZEN}, default NCH, helper function for modulo-NCH increment.
- Sub-module pic_rot_prio: combinational rotating priority encoder.
  - Inputs: vector, lp. Outputs: any, id, rank.
  - Instantiated twice: once on nmr, once on isr.
  - rank = (id - lp - 1) mod NCH; 0 is highest.
- The top level holds the FSM, the isr/lp registers and the EOI logic.

Test Plan:
- NCH=8, reset, irr=0x0A, imr=0 -> intr=1 after 1 cycle; two inta pulses -> vec_valid with vec_id=1, isr=0x02, intr=0 (ch3 blocked by ch1 in service).
- Continue: irr=0x01 -> intr=1 (ch0 preempts); INTA pair -> vec_id=0, isr=0x03; eoi_ns -> isr=0x02.
- lp=7, isr=0x02, smm=1, irr=0x0A -> intr=1; INTA pair -> vec_id=3, isr=0x0A.
- Rotation: aeoi=1, eoi_rot=1, irr=0x11, lp=7; INTA pair -> vec_id=0, isr=0, lp=0; next INTA pair -> vec_id=4, lp=4.
- Spurious: irr=0x04, first inta, drop irr to 0, second inta -> vec_id=7, spurious=1, isr unchanged.
- Edge cases:
  - eoi_sp lvl=2 and second inta delivering ch2 in the same cycle -> isr[2]=1.
  - rst asserted while FROZEN -> IDLE, isr=0, lp=7, intr=0 next cycle.
  - NCH=5 build: lp=4 wraps priority to ch0.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt priority core.
// Channel indices always wrap modulo the channel count.
package pic_pkg;

  typedef enum logic {
    IDLE,
    FROZEN
  } state_e;

  localparam int NCH_DEF = 8;

  function automatic int unsigned mod_inc(
    input int unsigned v,
    input int unsigned n
  );
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/pic_rot_prio.sv
// Rotating priority encoder: lp+1 is highest, lp is lowest.
// rank is the winner's distance from the top of the order.
module pic_rot_prio
  import pic_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int IDW = $clog2(NCH)
) (
  input  logic [NCH-1:0] vec,
  input  logic [IDW-1:0] lp,
  output logic           any,
  output logic [IDW-1:0] id,
  output logic [IDW-1:0] rank
);

  logic [IDW-1:0] ch;
  logic           found;

  always_comb begin
    found = 1'b0;
    id    = '0;
    rank  = '0;
    ch    = IDW'(mod_inc(32'(lp), NCH));
    for (int k = 0; k < NCH; k++) begin
      if (vec[ch] && !found) begin
        found = 1'b1;
        id    = ch;
        rank  = IDW'(k);
      end
      ch = IDW'(mod_inc(32'(ch), NCH));
    end
  end

  assign any = found;

endmodule

// File: rtl/pic_prio_core.sv
// 8259A-style priority core: ISR, rotating priority, INTA
// handshake and EOI handling.
module pic_prio_core
  import pic_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int IDW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] irr,
  input  logic [NCH-1:0] imr,
  input  logic           smm,
  input  logic           aeoi,
  input  logic           inta,
  input  logic           eoi_ns,
  input  logic           eoi_sp,
  input  logic [IDW-1:0] eoi_lvl,
  input  logic           eoi_rot,
  input  logic           set_lp,
  input  logic [IDW-1:0] lp_lvl,
  output logic           intr,
  output logic           vec_valid,
  output logic [IDW-1:0] vec_id,
  output logic           spurious,
  output logic [NCH-1:0] isr,
  output logic [IDW-1:0] lp
);

  localparam logic [IDW-1:0] LAST  = IDW'(NCH - 1);
  localparam logic [IDW:0]   NCH_W = (IDW + 1)'(NCH);

  state_e         state_q, state_d;
  logic [IDW-1:0] win_id_q, win_id_d;
  logic           win_ok_q, win_ok_d;
  logic           intr_q, intr_d;
  logic           vv_q, vv_d;
  logic [IDW-1:0] vid_q, vid_d;
  logic           sp_q, sp_d;
  logic [NCH-1:0] isr_q, isr_d;
  logic [IDW-1:0] lp_q, lp_d;

  logic [NCH-1:0] nmr;
  logic           nmr_any, isr_any;
  logic [IDW-1:0] nmr_id, nmr_rank;
  logic [IDW-1:0] isr_id, isr_rank;
  logic           pending;

  logic [NCH-1:0] set_v, clr_v;
  logic           aeoi_rot;
  logic           eoi_rot_hit;
  logic [IDW-1:0] eoi_rot_id;
  logic           sp_ok, lp_ok;

  assign nmr = irr & ~imr & (smm ? ~isr_q : {NCH{1'b1}});

  pic_rot_prio #(.NCH(NCH), .IDW(IDW)) u_nmr (
    .vec  (nmr),
    .lp   (lp_q),
    .any  (nmr_any),
    .id   (nmr_id),
    .rank (nmr_rank)
  );

  pic_rot_prio #(.NCH(NCH), .IDW(IDW)) u_isr (
    .vec  (isr_q),
    .lp   (lp_q),
    .any  (isr_any),
    .id   (isr_id),
    .rank (isr_rank)
  );

  // Equal priority never preempts the channel already in service.
  assign pending = nmr_any &&
    (smm || !isr_any || (nmr_rank < isr_rank));

  assign sp_ok = {1'b0, eoi_lvl} < NCH_W;
  assign lp_ok = {1'b0, lp_lvl} < NCH_W;

  always_comb begin
    state_d  = state_q;
    win_id_d = win_id_q;
    win_ok_d = win_ok_q;
    intr_d   = 1'b0;
    vv_d     = 1'b0;
    vid_d    = vid_q;
    sp_d     = sp_q;
    set_v    = '0;
    aeoi_rot = 1'b0;
    unique case (state_q)
      IDLE: begin
        intr_d = pending && !inta;
        if (inta) begin
          state_d  = FROZEN;
          win_id_d = nmr_id;
          win_ok_d = pending;
        end
      end
      FROZEN: begin
        if (inta) begin
          state_d = IDLE;
          vv_d    = 1'b1;
          if (win_ok_q) begin
            vid_d = win_id_q;
            sp_d  = 1'b0;
            if (!aeoi) set_v[win_id_q] = 1'b1;
            else       aeoi_rot = eoi_rot;
          end else begin
            vid_d = LAST;
            sp_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Specific EOI shadows a simultaneous non-specific one.
  always_comb begin
    clr_v       = '0;
    eoi_rot_hit = 1'b0;
    eoi_rot_id  = '0;
    if (eoi_sp) begin
      if (sp_ok) begin
        clr_v[eoi_lvl] = 1'b1;
        eoi_rot_hit    = eoi_rot;
        eoi_rot_id     = eoi_lvl;
      end
    end else if (eoi_ns && isr_any) begin
      clr_v[isr_id] = 1'b1;
      eoi_rot_hit   = eoi_rot;
      eoi_rot_id    = isr_id;
    end
  end

  always_comb begin
    isr_d = (isr_q & ~clr_v) | set_v;
    lp_d  = lp_q;
    if (eoi_rot_hit)   lp_d = eoi_rot_id;
    else if (aeoi_rot) lp_d = win_id_q;
    if (set_lp && lp_ok) lp_d = lp_lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_id_q <= '0;
      win_ok_q <= 1'b0;
      intr_q   <= 1'b0;
      vv_q     <= 1'b0;
      vid_q    <= '0;
      sp_q     <= 1'b0;
      isr_q    <= '0;
      lp_q     <= LAST;
    end else begin
      state_q  <= state_d;
      win_id_q <= win_id_d;
      win_ok_q <= win_ok_d;
      intr_q   <= intr_d;
      vv_q     <= vv_d;
      vid_q    <= vid_d;
      sp_q     <= sp_d;
      isr_q    <= isr_d;
      lp_q     <= lp_d;
    end
  end

  assign intr      = intr_q;
  assign vec_valid = vv_q;
  assign vec_id    = vid_q;
  assign spurious  = sp_q;
  assign isr       = isr_q;
  assign lp        = lp_q;

endmodule

// File: tb/tb_pic_prio_core.sv
// Bench for pic_prio_core: directed table, NCH=5 wrap
// sequence and randomized run against a reference model.
module tb_pic_prio_core;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] irr, imr;
  logic         smm, aeoi, inta;
  logic         eoi_ns, eoi_sp, eoi_rot;
  logic [2:0]   eoi_lvl, lp_lvl;
  logic         set_lp;
  logic         intr, vec_valid, spurious;
  logic [2:0]   vec_id, lp;
  logic [N-1:0] isr;

  logic         f_rst;
  logic [4:0]   f_irr, f_imr;
  logic         f_smm, f_aeoi, f_inta;
  logic         f_eoi_ns, f_eoi_sp, f_eoi_rot;
  logic [2:0]   f_eoi_lvl, f_lp_lvl;
  logic         f_set_lp;
  logic         f_intr, f_vv, f_sp;
  logic [2:0]   f_vid, f_lp;
  logic [4:0]   f_isr;

  int n_vec;
  int n_bad;

  // reference model state (post-edge values)
  logic         m_fz, m_ok, m_intr, m_vv, m_sp;
  int           m_win, m_vid, m_lp;
  logic [N-1:0] m_isr;

  pic_prio_core #(.NCH(N)) dut (
    .clk(clk), .rst(rst), .irr(irr), .imr(imr),
    .smm(smm), .aeoi(aeoi), .inta(inta),
    .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_lvl(eoi_lvl),
    .eoi_rot(eoi_rot), .set_lp(set_lp), .lp_lvl(lp_lvl),
    .intr(intr), .vec_valid(vec_valid), .vec_id(vec_id),
    .spurious(spurious), .isr(isr), .lp(lp)
  );

  pic_prio_core #(.NCH(5)) dut5 (
    .clk(clk), .rst(f_rst), .irr(f_irr), .imr(f_imr),
    .smm(f_smm), .aeoi(f_aeoi), .inta(f_inta),
    .eoi_ns(f_eoi_ns), .eoi_sp(f_eoi_sp), .eoi_lvl(f_eoi_lvl),
    .eoi_rot(f_eoi_rot), .set_lp(f_set_lp), .lp_lvl(f_lp_lvl),
    .intr(f_intr), .vec_valid(f_vv), .vec_id(f_vid),
    .spurious(f_sp), .isr(f_isr), .lp(f_lp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst, irr, smm, aeoi, inta, ens, esp, elvl, erot, slp, llvl;
    int e_intr, e_vv, e_vid, e_sp, e_isr, e_lp;
  } vec_t;

  vec_t tv[40];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // distance below the top of the rotated order; 0 is highest
  function automatic int prio(input int ch, input int lpv);
    return (ch - lpv - 1 + 2 * N) % N;
  endfunction

  function automatic int top(input logic [N-1:0] v, input int lpv);
    int best = -1;
    for (int c = 0; c < N; c++)
      if (v[c] && (best < 0 || prio(c, lpv) < prio(best, lpv)))
        best = c;
    return best;
  endfunction

  task automatic model_step();
    logic [N-1:0] nmr, clr, setv;
    int hn, hi, nlp;
    logic pend;
    if (rst) begin
      m_fz = 0; m_ok = 0; m_win = 0; m_intr = 0; m_vv = 0;
      m_vid = 0; m_sp = 0; m_isr = '0; m_lp = N - 1;
      return;
    end
    nmr = irr & ~imr;
    if (smm) nmr = nmr & ~m_isr;
    hn = top(nmr, m_lp);
    hi = top(m_isr, m_lp);
    pend = (hn >= 0) &&
      (smm || hi < 0 || prio(hn, m_lp) < prio(hi, m_lp));
    clr = '0;
    setv = '0;
    nlp = m_lp;
    m_vv = 0;
    if (!m_fz) begin
      m_intr = pend && !inta;
      if (inta) begin
        m_fz = 1;
        m_win = (hn < 0) ? 0 : hn;
        m_ok = pend;
      end
    end else begin
      m_intr = 0;
      if (inta) begin
        m_fz = 0;
        m_vv = 1;
        if (m_ok) begin
          m_vid = m_win;
          m_sp = 0;
          if (!aeoi) setv[m_win] = 1'b1;
          else if (eoi_rot) nlp = m_win;
        end else begin
          m_vid = N - 1;
          m_sp = 1;
        end
      end
    end
    if (eoi_sp) begin
      if (int'(eoi_lvl) < N) begin
        clr[eoi_lvl] = 1'b1;
        if (eoi_rot) nlp = int'(eoi_lvl);
      end
    end else if (eoi_ns && hi >= 0) begin
      clr[hi] = 1'b1;
      if (eoi_rot) nlp = hi;
    end
    m_isr = (m_isr & ~clr) | setv;
    if (set_lp && int'(lp_lvl) < N) nlp = int'(lp_lvl);
    m_lp = nlp;
  endtask

  task automatic clear_inputs();
    irr = '0; imr = '0; smm = 0; aeoi = 0; inta = 0;
    eoi_ns = 0; eoi_sp = 0; eoi_lvl = '0; eoi_rot = 0;
    set_lp = 0; lp_lvl = '0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clear_inputs();
    rst = 1;
    f_rst = 1; f_irr = '0; f_imr = '0; f_smm = 0; f_aeoi = 0;
    f_inta = 0; f_eoi_ns = 0; f_eoi_sp = 0; f_eoi_lvl = '0;
    f_eoi_rot = 0; f_set_lp = 0; f_lp_lvl = '0;

    // rst,irr,smm,aeoi,inta,ens,esp,elvl,erot,slp,llvl | intr,vv,vid,sp,isr,lp
    tv[0]  = '{1,'h00,0,0,0,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[1]  = '{0,'h0A,0,0,0,0,0,0,0,0,0, 1,0,0,0,'h00,7};
    tv[2]  = '{0,'h0A,0,0,1,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[3]  = '{0,'h0A,0,0,1,0,0,0,0,0,0, 0,1,1,0,'h02,7};
    tv[4]  = '{0,'h0A,0,0,0,0,0,0,0,0,0, 0,0,1,0,'h02,7};
    tv[5]  = '{0,'h01,0,0,0,0,0,0,0,0,0, 1,0,1,0,'h02,7};
    tv[6]  = '{0,'h01,0,0,1,0,0,0,0,0,0, 0,0,1,0,'h02,7};
    tv[7]  = '{0,'h01,0,0,1,0,0,0,0,0,0, 0,1,0,0,'h03,7};
    tv[8]  = '{0,'h00,0,0,0,1,0,0,0,0,0, 0,0,0,0,'h02,7};
    tv[9]  = '{0,'h0A,1,0,0,0,0,0,0,0,0, 1,0,0,0,'h02,7};
    tv[10] = '{0,'h0A,1,0,1,0,0,0,0,0,0, 0,0,0,0,'h02,7};
    tv[11] = '{0,'h0A,1,0,1,0,0,0,0,0,0, 0,1,3,0,'h0A,7};
    tv[12] = '{1,'h00,0,0,0,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[13] = '{0,'h11,0,1,0,0,0,0,1,0,0, 1,0,0,0,'h00,7};
    tv[14] = '{0,'h11,0,1,1,0,0,0,1,0,0, 0,0,0,0,'h00,7};
    tv[15] = '{0,'h11,0,1,1,0,0,0,1,0,0, 0,1,0,0,'h00,0};
    tv[16] = '{0,'h11,0,1,0,0,0,0,1,0,0, 1,0,0,0,'h00,0};
    tv[17] = '{0,'h11,0,1,1,0,0,0,1,0,0, 0,0,0,0,'h00,0};
    tv[18] = '{0,'h11,0,1,1,0,0,0,1,0,0, 0,1,4,0,'h00,4};
    tv[19] = '{1,'h00,0,0,0,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[20] = '{0,'h04,0,0,0,0,0,0,0,0,0, 1,0,0,0,'h00,7};
    tv[21] = '{0,'h00,0,0,1,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[22] = '{0,'h00,0,0,1,0,0,0,0,0,0, 0,1,7,1,'h00,7};
    tv[23] = '{0,'h04,0,0,0,0,0,0,0,0,0, 1,0,7,1,'h00,7};
    tv[24] = '{0,'h04,0,0,1,0,0,0,0,0,0, 0,0,7,1,'h00,7};
    tv[25] = '{0,'h00,0,0,1,0,0,0,0,0,0, 0,1,2,0,'h04,7};
    tv[26] = '{1,'h00,0,0,0,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[27] = '{0,'h04,0,0,0,0,0,0,0,0,0, 1,0,0,0,'h00,7};
    tv[28] = '{0,'h04,0,0,1,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[29] = '{0,'h04,0,0,1,0,1,2,0,0,0, 0,1,2,0,'h04,7};
    tv[30] = '{0,'h01,0,0,0,0,0,0,0,0,0, 1,0,2,0,'h04,7};
    tv[31] = '{0,'h01,0,0,1,0,0,0,0,0,0, 0,0,2,0,'h04,7};
    tv[32] = '{1,'h01,0,0,0,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[33] = '{0,'h01,0,0,0,0,0,0,0,0,0, 1,0,0,0,'h00,7};
    tv[34] = '{0,'h01,0,0,1,0,0,0,0,0,0, 0,0,0,0,'h00,7};
    tv[35] = '{0,'h01,0,0,1,0,0,0,0,0,0, 0,1,0,0,'h01,7};
    tv[36] = '{0,'h00,0,0,0,1,0,0,1,1,3, 0,0,0,0,'h00,3};
    tv[37] = '{0,'h09,0,0,0,0,0,0,0,0,0, 1,0,0,0,'h00,3};
    tv[38] = '{0,'h09,0,0,1,0,0,0,0,0,0, 0,0,0,0,'h00,3};
    tv[39] = '{0,'h09,0,0,1,0,0,0,0,0,0, 0,1,0,0,'h01,3};

    // NCH=5 build: wrap of the priority order past the last channel
    tick();
    chk("n5_rst_lp", f_lp, 4);
    chk("n5_rst_isr", f_isr, 0);
    f_rst = 0; f_set_lp = 1; f_lp_lvl = 3; f_irr = 5'b10001;
    tick();
    chk("n5_lp3", f_lp, 3);
    chk("n5_intr", f_intr, 1);
    f_set_lp = 0; f_inta = 1;
    tick();
    chk("n5_frz_intr", f_intr, 0);
    tick();
    chk("n5_vv_a", f_vv, 1);
    chk("n5_vid_a", f_vid, 4);
    chk("n5_isr_a", f_isr, 5'b10000);
    f_inta = 0; f_eoi_sp = 1; f_eoi_lvl = 4;
    tick();
    chk("n5_eoi4", f_isr, 0);
    f_eoi_sp = 0; f_set_lp = 1; f_lp_lvl = 4;
    tick();
    chk("n5_lp4", f_lp, 4);
    f_lp_lvl = 5;
    tick();
    chk("n5_lp_bad_ign", f_lp, 4);
    chk("n5_intr_b", f_intr, 1);
    f_set_lp = 0; f_inta = 1;
    tick();
    tick();
    chk("n5_vid_wrap", f_vid, 0);
    chk("n5_sp_b", f_sp, 0);
    chk("n5_isr_b", f_isr, 5'b00001);
    f_inta = 0; f_eoi_sp = 1; f_eoi_lvl = 6;
    tick();
    chk("n5_eoi_bad_ign", f_isr, 5'b00001);
    f_eoi_lvl = 0;
    tick();
    chk("n5_eoi0", f_isr, 0);
    f_eoi_sp = 0; f_rst = 1;

    // directed table on the NCH=8 core
    for (int i = 0; i < 40; i++) begin
      rst = tv[i].rst[0];
      irr = 8'(tv[i].irr);
      imr = '0;
      smm = tv[i].smm[0];
      aeoi = tv[i].aeoi[0];
      inta = tv[i].inta[0];
      eoi_ns = tv[i].ens[0];
      eoi_sp = tv[i].esp[0];
      eoi_lvl = 3'(tv[i].elvl);
      eoi_rot = tv[i].erot[0];
      set_lp = tv[i].slp[0];
      lp_lvl = 3'(tv[i].llvl);
      tick();
      chk($sformatf("t%0d_intr", i), intr, tv[i].e_intr);
      chk($sformatf("t%0d_vv", i), vec_valid, tv[i].e_vv);
      chk($sformatf("t%0d_vid", i), vec_id, tv[i].e_vid);
      chk($sformatf("t%0d_sp", i), spurious, tv[i].e_sp);
      chk($sformatf("t%0d_isr", i), isr, tv[i].e_isr);
      chk($sformatf("t%0d_lp", i), lp, tv[i].e_lp);
    end

    // randomized run against the reference model
    for (int i = 0; i < 4000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      irr = ($urandom_range(0, 3) == 0) ? '0 : 8'($urandom);
      imr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : '0;
      smm = ($urandom_range(0, 5) == 0);
      if (i % 700 == 0) aeoi = 1'($urandom);
      inta = ($urandom_range(0, 2) == 0);
      eoi_ns = ($urandom_range(0, 7) == 0);
      eoi_sp = ($urandom_range(0, 9) == 0);
      eoi_lvl = 3'($urandom);
      eoi_rot = 1'($urandom);
      set_lp = ($urandom_range(0, 19) == 0);
      lp_lvl = 3'($urandom);
      model_step();
      tick();
      chk("r_intr", intr, m_intr);
      chk("r_vv", vec_valid, m_vv);
      chk("r_vid", vec_id, m_vid);
      chk("r_sp", spurious, m_sp);
      chk("r_isr", isr, m_isr);
      chk("r_lp", lp, m_lp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
